dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one data_memory instance between two requesters: port 0 is the pipeline LSU (MEM stage), port 1 is a DMA/debug master.
- Round-robin arbitration with a valid/ready request handshake per port.
- Handles alignment: byte-lane enables, store-data replication, load extraction and sign/zero extension.
- Returns a registered response one cycle after acceptance. Sits between the requesters and data_memory; drives its we/valid/addr/wdata/byte_enable and consumes its combinational rdata.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MEM_DEPTH, 1024, words in the attached data_memory; used for the range check.

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port accept; transfer when valid&&ready
- req_we  in  2  1 = store, 0 = load
- req_size  in  2x2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  2  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  2xXLEN  byte address
- req_wdata  in  2xXLEN  store data, right-aligned
- resp_valid  out  2  one-cycle pulse per accepted request
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size or out of range
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- mem_valid, mem_we  out  1  to data_memory
- mem_addr  out  XLEN  word-aligned address (addr[1:0]=00)
- mem_wdata  out  XLEN  lane-replicated store data
- mem_byte_enable  out  4  to data_memory
- mem_rdata  in  XLEN  from data_memory (combinational read)

Behaviour:
- Reset (async, rst=1): last_grant=1 so port 0 wins first; resp_valid=0, resp_err=0, resp_rdata=0; all counters 0. mem_valid is forced 0 while rst is high.
- Grant is combinational from req_valid and last_grant:
  - single valid port: that port wins;
  - both valid: the port != last_grant wins.
- req_ready = grant. At most one bit of req_ready is set; none when neither port is valid. No back-pressure on responses.
- On acceptance (posedge), last_grant <= granted port.
- Checks on the granted request, all combinational in the same cycle:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - illegal size: size=11;
  - out of range: addr[XLEN-1:2] >= MEM_DEPTH.
- Error: mem_valid=0 and the memory is untouched; next cycle resp_valid[i]=1, resp_err=1, resp_rdata=0.
- Legal access drives mem_valid=1, mem_we=req_we.
  - byte_enable: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - wdata: byte replicated x4, half replicated x2, word as-is.
  - A store commits at the negedge of the grant cycle.
- Load response: at the grant posedge, capture mem_rdata >> (8*addr[1:0]), extend to XLEN per size/unsigned, register into resp_rdata. resp_valid pulses the next cycle, so load latency is 1.
- Store response: resp_valid pulses with resp_rdata=0, resp_err=0.
- Read-after-write: a load granted the cycle after a store to the same word sees the new data, because the write lands at the intervening negedge.
- Back-to-back: a new request may be accepted every cycle. Each response follows its request by exactly one cycle and carries only that request's data.
- Reset mid-operation clears any pending response. The accepted request is lost, except a store already past its negedge.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_grants0, stat_grants1, stat_conflicts, stat_errors (32 bits each, saturating, cleared by rst). stat_conflicts counts cycles with both req_valid high.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef mem_size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL};
  - the byte-enable/replication function and the load-extend function (shared with the LSU).
- One sub-module is natural: dmem_rr_arb (2-way round-robin grant plus last_grant register).

Test Plan:
- Both ports valid every cycle, legal word loads → grants alternate 0,1,0,1 starting at port 0; each resp_valid lands one cycle later on the matching bit.
- Port 0 stores byte 0xA5 to addr 0x13, then loads word 0x10 → mem_byte_enable=1000, mem_wdata=0xA5A5A5A5; load returns 0xA5000000.
- Signed half load at 0x22 where word 0x20 = 0x8001_7FFF → resp_rdata=0xFFFF8001; the unsigned variant returns 0x00008001.
- Word load at 0x06, half at 0x01, size=11, addr 0x1000 (MEM_DEPTH=1024) → mem_valid=0 each time; resp_err=1 and resp_rdata=0 next cycle.
- Store at cycle N, load of the same word at N+1 → the load returns the new data.
- Assert rst while resp_valid is pending → resp_valid drops immediately; port 0 is granted first after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for data-memory access, used by the arbiter and the LSU.
//   mem_size_e   : access size encoding (byte / half / word / illegal)
//   store_lane_t : byte-lane enables plus lane-replicated store data
//   store_lanes  : builds byte enables and replicated write data for a store
//   load_extend  : right-aligns a memory word for a load and sign/zero-extends
// Only a 32-bit datapath is supported.
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] wdata;
   } store_lane_t;

   // Replicating the store data across the word means the memory only has to
   // honour the byte enables; no lane shifting is needed on its side.
   function automatic store_lane_t store_lanes(input mem_size_e   sz,
                                               input logic [1:0]  off,
                                               input logic [31:0] data);
      store_lane_t s;
      case (sz)
         SZ_BYTE: begin
            s.be    = 4'b0001 << off;
            s.wdata = {4{data[7:0]}};
         end
         SZ_HALF: begin
            s.be    = 4'b0011 << off;
            s.wdata = {2{data[15:0]}};
         end
         SZ_WORD: begin
            s.be    = 4'b1111;
            s.wdata = data;
         end
         default: begin
            s.be    = 4'b0000;
            s.wdata = data;
         end
      endcase
      return s;
   endfunction

   function automatic logic [31:0] load_extend(input mem_size_e   sz,
                                               input logic        uns,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] res;
      sh = rdata >> {off, 3'b000};
      case (sz)
         SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
         SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// -----------------------------------------------------------------------------
// dmem_rr_arb
// Two-way round-robin arbiter with the last-grant history register.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-port request valid
//   grant      : one-hot grant (zero when nobody requests); doubles as ready
//   grant_idx  : index of the granted port (meaningful only when |grant)
// last_grant resets to 1 so that port 0 wins the first contended cycle.
// -----------------------------------------------------------------------------
module dmem_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign grant_idx = grant[1];

   // A grant is always accepted because ready equals grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data_memory between the pipeline LSU (port 0) and a DMA/debug
// master (port 1). Round-robin grant, alignment/range checking, byte-lane
// generation, store replication and load extension. One registered response
// per accepted request, one cycle after acceptance.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : per-port handshake (ready is the one-hot grant)
//   req_we            : 1 store, 0 load
//   req_size          : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      : load zero-extend when 1, sign-extend when 0
//   req_addr/wdata    : byte address, right-aligned store data
//   resp_valid        : one-cycle pulse on the bit of the answered port
//   resp_err          : misaligned, illegal size or out of range
//   resp_rdata        : extended load data, 0 for stores and errors
//   mem_*             : data_memory interface (combinational mem_rdata)
//
// Optional build macro DMEM_ARB_STATS_EN adds saturating 32-bit counters
// stat_grants0, stat_grants1, stat_conflicts, stat_errors.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0]           req_we,
   input  logic [1:0][1:0]      req_size,
   input  logic [1:0]           req_unsigned,
   input  logic [1:0][XLEN-1:0] req_addr,
   input  logic [1:0][XLEN-1:0] req_wdata,
   output logic [1:0]           resp_valid,
   output logic                 resp_err,
   output logic [XLEN-1:0]      resp_rdata,
   output logic                 mem_valid,
   output logic                 mem_we,
   output logic [XLEN-1:0]      mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   output logic [3:0]           mem_byte_enable,
   input  logic [XLEN-1:0]      mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]          stat_grants0,
   output logic [31:0]          stat_grants1,
   output logic [31:0]          stat_conflicts,
   output logic [31:0]          stat_errors
`endif
);

   localparam logic [XLEN-1:0] DEPTH_LIM = XLEN'(MEM_DEPTH);

   logic [1:0]      grant;
   logic            sel;
   logic            acc_p0;
   mem_size_e       sz_p0;
   logic [XLEN-1:0] addr_p0;
   logic [XLEN-1:0] wdata_p0;
   logic            we_p0;
   logic            uns_p0;
   logic [1:0]      off_p0;
   logic            misalign_p0;
   logic            ill_p0;
   logic            oor_p0;
   logic            err_p0;
   logic            legal_p0;
   store_lane_t     lanes_p0;

   logic [1:0]      resp_vld_p1;
   logic            resp_err_p1;
   logic [XLEN-1:0] resp_rdata_p1;

   dmem_rr_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .grant     (grant),
      .grant_idx (sel)
   );

   assign req_ready = grant;
   assign acc_p0    = |grant;

   // ---- stage p0: granted request, checks and memory drive ----
   always_comb begin
      sz_p0    = mem_size_e'(req_size[sel]);
      addr_p0  = req_addr[sel];
      wdata_p0 = req_wdata[sel];
      we_p0    = req_we[sel];
      uns_p0   = req_unsigned[sel];
      off_p0   = addr_p0[1:0];
   end

   assign misalign_p0 = ((sz_p0 == SZ_HALF) && off_p0[0]) ||
                        ((sz_p0 == SZ_WORD) && (off_p0 != 2'b00));
   assign ill_p0      = (sz_p0 == SZ_ILL);
   assign oor_p0      = ({2'b00, addr_p0[XLEN-1:2]} >= DEPTH_LIM);
   assign err_p0      = misalign_p0 | ill_p0 | oor_p0;
   assign legal_p0    = acc_p0 & ~err_p0;
   assign lanes_p0    = store_lanes(sz_p0, off_p0, wdata_p0);

   // mem_valid is masked by rst so nothing reaches the memory during reset.
   assign mem_valid       = legal_p0 & ~rst;
   assign mem_we          = legal_p0 & we_p0;
   assign mem_addr        = {addr_p0[XLEN-1:2], 2'b00};
   assign mem_wdata       = lanes_p0.wdata;
   assign mem_byte_enable = legal_p0 ? lanes_p0.be : 4'b0000;

   // ---- stage p1: registered response ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld_p1   <= 2'b00;
         resp_err_p1   <= 1'b0;
         resp_rdata_p1 <= '0;
      end else begin
         resp_vld_p1   <= grant;
         resp_err_p1   <= acc_p0 & err_p0;
         resp_rdata_p1 <= (legal_p0 && !we_p0) ?
                          load_extend(sz_p0, uns_p0, off_p0, mem_rdata) : '0;
      end
   end

   assign resp_valid = resp_vld_p1;
   assign resp_err   = resp_err_p1;
   assign resp_rdata = resp_rdata_p1;

`ifdef DMEM_ARB_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grants0   <= '0;
         stat_grants1   <= '0;
         stat_conflicts <= '0;
         stat_errors    <= '0;
      end else begin
         if (grant[0])          stat_grants0   <= sat_inc(stat_grants0);
         if (grant[1])          stat_grants1   <= sat_inc(stat_grants1);
         if (&req_valid)        stat_conflicts <= sat_inc(stat_conflicts);
         if (acc_p0 && err_p0)  stat_errors    <= sat_inc(stat_errors);
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, req_we, req_unsigned, resp_valid;
   logic [1:0][1:0]  req_size;
   logic [1:0][31:0] req_addr, req_wdata;
   logic             resp_err;
   logic [31:0]      resp_rdata;
   logic             mem_valid, mem_we;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata;
   logic [3:0]       mem_byte_enable;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.XLEN(32), .MEM_DEPTH(1024)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_size        (req_size),
      .req_unsigned    (req_unsigned),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_err        (resp_err),
      .resp_rdata      (resp_rdata),
      .mem_valid       (mem_valid),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata)
   );

   // Deterministic initial memory contents, a few words pinned for the
   // directed cases.
   function automatic logic [31:0] init_word(input int w);
      logic [31:0] v;
      v = (32'(w) * 32'h9E37_79B9) ^ 32'h5A3C_96E1;
      if (w == 4) v = 32'h0000_0000;   // byte 0x10
      if (w == 8) v = 32'h8001_7FFF;   // byte 0x20
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- data_memory stand-in ----------------
   logic [31:0] pmem [0:1023];
   assign mem_rdata = pmem[mem_addr[11:2]];

   initial begin
      for (int w = 0; w < 1024; w++) pmem[w] <= init_word(w);
      forever begin
         @(negedge clk);
         if (mem_valid && mem_we)
            for (int k = 0; k < 4; k++)
               if (mem_byte_enable[k]) pmem[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
   end

   // ---------------- behavioural model + compare ----------------
   logic [7:0] rmem [0:4095];

   initial begin
      int          last_g;
      int          g, n, sz;
      int unsigned a, off;
      bit          bad, pend, we, uns;
      logic [1:0]  exp_rv;
      bit          exp_err;
      logic [31:0] exp_rd, wd, wexp, v, w0;
      logic [3:0]  be_e;
      for (int w = 0; w < 1024; w++) begin
         w0 = init_word(w);
         for (int k = 0; k < 4; k++) rmem[4*w + k] = w0[8*k +: 8];
      end
      last_g = 1;
      pend   = 0;
      exp_rv = 2'b00; exp_err = 0; exp_rd = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_err", 32'(resp_err), 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_mem_valid", 32'(mem_valid), 0);
            pend   = 0;
            last_g = 1;
         end else begin
            if (pend) begin
               chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
               chk("resp_err", 32'(resp_err), 32'(exp_err));
               chk("resp_rdata", resp_rdata, exp_rd);
            end else begin
               chk("idle_resp_valid", 32'(resp_valid), 0);
            end
            if (req_valid == 2'b11)  g = 1 - last_g;
            else if (req_valid[0])   g = 0;
            else if (req_valid[1])   g = 1;
            else                     g = -1;
            chk("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
            pend = 0;
            if (g >= 0) begin
               a   = req_addr[g];
               sz  = int'(req_size[g]);
               we  = req_we[g];
               uns = req_unsigned[g];
               wd  = req_wdata[g];
               n   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
               bad = (sz == 3) || ((a % n) != 0) || ((a / 4) >= 1024);
               chk("mem_valid", 32'(mem_valid), 32'(!bad));
               exp_rd = 0;
               if (!bad) begin
                  off  = a % 4;
                  be_e = 4'b0000;
                  for (int k = 0; k < 4; k++)
                     if (k >= off && k < off + n) be_e[k] = 1'b1;
                  chk("mem_we", 32'(mem_we), 32'(we));
                  chk("mem_addr", mem_addr, a - off);
                  chk("mem_byte_enable", 32'(mem_byte_enable), 32'(be_e));
                  if (we) begin
                     for (int k = 0; k < 4; k++) wexp[8*k +: 8] = wd[8*(k % n) +: 8];
                     chk("mem_wdata", mem_wdata, wexp);
                     for (int j = 0; j < n; j++) rmem[a + j] = wd[8*j +: 8];
                  end else begin
                     v = 0;
                     for (int j = 0; j < n; j++) v[8*j +: 8] = rmem[a + j];
                     if (!uns && n < 4 && v[8*n - 1])
                        for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
                     exp_rd = v;
                  end
               end
               pend    = 1;
               exp_rv  = 2'(1 << g);
               exp_err = bad;
               last_g  = g;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid    = 2'b00;
      req_we       = 2'b00;
      req_unsigned = 2'b00;
      req_size     = '0;
      req_addr     = '0;
      req_wdata    = '0;
   endtask

   task automatic req0(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
      idle();
      req_valid       = 2'b01;
      req_we[0]       = we;
      req_size[0]     = sz;
      req_unsigned[0] = uns;
      req_addr[0]     = addr;
      req_wdata[0]    = wd;
   endtask

   initial begin
      logic [31:0] ra;
      logic [1:0]  rs;
      int          r;
      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Contended word loads: grants alternate starting at port 0.
      req_valid = 2'b11;
      req_size  = {2'b10, 2'b10};
      req_addr  = {32'h44, 32'h40};
      @(negedge clk); chk("alt_grant0", 32'(req_ready), 32'h1);
      tick(); @(negedge clk);
      chk("alt_grant1", 32'(req_ready), 32'h2);
      chk("alt_resp0", 32'(resp_valid), 32'h1);
      tick(); @(negedge clk);
      chk("alt_grant2", 32'(req_ready), 32'h1);
      chk("alt_resp1", 32'(resp_valid), 32'h2);
      tick(); @(negedge clk);
      chk("alt_grant3", 32'(req_ready), 32'h2);
      tick(); idle();

      // Byte store then word load of the same word.
      req0(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5);
      @(negedge clk);
      chk("sb_be", 32'(mem_byte_enable), 32'h8);
      chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("sb_addr", mem_addr, 32'h10);
      tick(); req0(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("sb_resp", resp_rdata, 32'h0);
      tick(); idle();
      @(negedge clk);
      chk("lw_after_sb", resp_rdata, 32'hA500_0000);

      // Half loads at 0x22, signed then unsigned.
      tick(); req0(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
      tick(); req0(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
      @(negedge clk); chk("lh_signed", resp_rdata, 32'hFFFF_8001);
      tick(); idle();
      @(negedge clk); chk("lh_unsigned", resp_rdata, 32'h0000_8001);

      // Error cases: misaligned word, misaligned half, illegal size, range.
      for (int e = 0; e < 4; e++) begin
         tick();
         case (e)
            0: req0(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
            1: req0(1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
            2: req0(1'b1, 2'b11, 1'b0, 32'h08, 32'h1234_5678);
            default: req0(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
         endcase
         @(negedge clk); chk("err_mem_valid", 32'(mem_valid), 32'h0);
         tick(); idle();
         @(negedge clk);
         chk("err_flag", 32'(resp_err), 32'h1);
         chk("err_rdata", resp_rdata, 32'h0);
      end

      // Store at N, load same word at N+1.
      tick(); req0(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF);
      tick(); req0(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      tick(); idle();
      @(negedge clk); chk("raw_word", resp_rdata, 32'hDEAD_BEEF);

      // Reset with a response pending.
      tick(); req0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      tick(); idle();
      chk("pend_before_rst", 32'(resp_valid), 32'h1);
      rst = 1'b1;
      #1 chk("rst_drops_resp", 32'(resp_valid), 32'h0);
      tick(); tick();
      rst = 1'b0;
      req_valid = 2'b11;
      req_size  = {2'b10, 2'b10};
      req_addr  = {32'h48, 32'h4C};
      @(negedge clk); chk("post_rst_grant", 32'(req_ready), 32'h1);
      tick(); idle();

      // Randomized traffic, checked by the model every cycle.
      repeat (800) begin
         req_valid = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            r  = $urandom_range(0, 9);
            rs = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            ra = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                               : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
               if (rs == 2'b01) ra[0]   = 1'b0;
               if (rs == 2'b10) ra[1:0] = 2'b00;
            end
            req_size[p]     = rs;
            req_addr[p]     = ra;
            req_we[p]       = 1'($urandom_range(0, 1));
            req_unsigned[p] = 1'($urandom_range(0, 1));
            req_wdata[p]    = $urandom;
         end
         tick();
      end
      idle();
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
